returner: RTL and testbench

Completion stage directly downstream of the burst handler. Accepts one completed request per cycle (read data or write completion), reorders read data by its read-queue index, and hands it to the front end strictly in index order over a valid/ready port. Write completions go to a separate small ack FIFO. The burst handler has no backpressure, so this block must absorb every input beat.

---
 rtl/returner.sv | 208 ++++++++++++++++++++
 tb/tb_returner.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/returner.sv
// returner: completion stage behind the burst handler.
// Read beats are parked in a reorder buffer indexed by read-queue index and
// leave through a registered valid/ready port strictly in index order.
// Write completions are queued in a small ack FIFO; a push that finds the FIFO
// full (with no pop in the same cycle) is dropped and flagged in wr_overflow.
// Optional macro RETURNER_DUP_CHECK_EN: a read that targets a still-occupied
// slot is dropped and flagged in dup_error (otherwise it overwrites the slot).
module returner #(
  parameter int data_width       = 16,
  parameter int read_entries_log = 4,
  parameter int wr_ack_depth     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        returner_valid,
  input  logic                        returner_type,
  input  logic [data_width-1:0]       returner_data,
  input  logic [read_entries_log-1:0] returner_index,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [data_width-1:0]       rd_data,
  output logic [read_entries_log-1:0] rd_index,
  output logic                        wr_ack_valid,
  input  logic                        wr_ack_ready,
  output logic [read_entries_log-1:0] wr_ack_index,
  output logic                        wr_overflow,
  output logic                        dup_error
);

  localparam int  Slots       = 1 << read_entries_log;
  localparam int  AckPtrW     = $clog2(wr_ack_depth);
  localparam int  AckCntW     = AckPtrW + 1;
  localparam logic RTypeRead  = 1'b0;
  localparam logic RTypeWrite = 1'b1;

  // ---------------------------------------------------------------- ROB state
  logic [Slots-1:0]            slot_valid_q;
  logic [data_width-1:0]       slot_data_q [Slots];
  logic [read_entries_log-1:0] head_q, head_d;

  logic                        rd_valid_q, rd_valid_d;
  logic [data_width-1:0]       rd_data_q, rd_data_d;
  logic [read_entries_log-1:0] rd_index_q, rd_index_d;

  logic rd_beat;
  logic rd_write;
  logic dup_hit;
  logic rd_load;

  assign rd_beat = returner_valid && (returner_type == RTypeRead);

`ifdef RETURNER_DUP_CHECK_EN
  // A beat aimed at a slot that still holds undelivered data is discarded.
  assign dup_hit  = rd_beat && slot_valid_q[returner_index];
  assign rd_write = rd_beat && !dup_hit;
`else
  assign dup_hit  = 1'b0;
  assign rd_write = rd_beat;
`endif

  // The head check uses registered slot_valid, so a beat landing on the head
  // slot this edge is only seen at the following edge.
  assign rd_load = slot_valid_q[head_q] && (!rd_valid_q || rd_ready);

  // Per-slot occupancy: a captured beat sets the bit, leaving the ROB clears it.
  // Set has priority so an overwrite of the departing head slot is kept.
  for (genvar gi = 0; gi < Slots; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        slot_valid_q[gi] <= 1'b0;
      end else if (rd_write && (returner_index == read_entries_log'(gi))) begin
        slot_valid_q[gi] <= 1'b1;
      end else if (rd_load && (head_q == read_entries_log'(gi))) begin
        slot_valid_q[gi] <= 1'b0;
      end
    end
  end

  // Slot payload storage; contents only matter while the slot is valid.
  always_ff @(posedge clk) begin
    if (rd_write) begin
      slot_data_q[returner_index] <= returner_data;
    end
  end

  // Next state of the in-order output register and the head pointer.
  always_comb begin
    head_d     = head_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_index_d = rd_index_q;
    if (rd_load) begin
      rd_valid_d = 1'b1;
      rd_data_d  = slot_data_q[head_q];
      rd_index_d = head_q;
      head_d     = head_q + read_entries_log'(1);
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  // Output register and head pointer state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_index_q <= '0;
    end else begin
      head_q     <= head_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_index_q <= rd_index_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_index = rd_index_q;

  // ------------------------------------------------------------ write-ack FIFO
  logic [read_entries_log-1:0] ack_mem_q [wr_ack_depth];
  logic [AckPtrW-1:0]          ack_wr_ptr_q, ack_wr_ptr_d;
  logic [AckPtrW-1:0]          ack_rd_ptr_q, ack_rd_ptr_d;
  logic [AckCntW-1:0]          ack_count_q, ack_count_d;
  logic                        wr_overflow_q, wr_overflow_d;

  logic wr_beat;
  logic ack_full;
  logic ack_empty;
  logic ack_push;
  logic ack_pop;

  assign wr_beat   = returner_valid && (returner_type == RTypeWrite);
  assign ack_full  = (ack_count_q == AckCntW'(wr_ack_depth));
  assign ack_empty = (ack_count_q == '0);
  assign ack_pop   = !ack_empty && wr_ack_ready;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign ack_push  = wr_beat && (!ack_full || ack_pop);

  // FIFO pointer/count bookkeeping and the sticky drop flag.
  always_comb begin
    ack_wr_ptr_d  = ack_wr_ptr_q;
    ack_rd_ptr_d  = ack_rd_ptr_q;
    ack_count_d   = ack_count_q;
    wr_overflow_d = wr_overflow_q;
    if (ack_push) begin
      ack_wr_ptr_d = ack_wr_ptr_q + AckPtrW'(1);
    end
    if (ack_pop) begin
      ack_rd_ptr_d = ack_rd_ptr_q + AckPtrW'(1);
    end
    case ({ack_push, ack_pop})
      2'b10:   ack_count_d = ack_count_q + AckCntW'(1);
      2'b01:   ack_count_d = ack_count_q - AckCntW'(1);
      default: ack_count_d = ack_count_q;
    endcase
    if (wr_beat && !ack_push) begin
      wr_overflow_d = 1'b1;
    end
  end

  // FIFO control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_wr_ptr_q  <= '0;
      ack_rd_ptr_q  <= '0;
      ack_count_q   <= '0;
      wr_overflow_q <= 1'b0;
    end else begin
      ack_wr_ptr_q  <= ack_wr_ptr_d;
      ack_rd_ptr_q  <= ack_rd_ptr_d;
      ack_count_q   <= ack_count_d;
      wr_overflow_q <= wr_overflow_d;
    end
  end

  // FIFO storage; entries are only observed while the count covers them.
  always_ff @(posedge clk) begin
    if (ack_push) begin
      ack_mem_q[ack_wr_ptr_q] <= returner_index;
    end
  end

  assign wr_ack_valid = !ack_empty;
  // Forced to zero when empty so the port reads 0 out of reset.
  assign wr_ack_index = ack_empty ? '0 : ack_mem_q[ack_rd_ptr_q];
  assign wr_overflow  = wr_overflow_q;

  // ----------------------------------------------------------- duplicate flag
`ifdef RETURNER_DUP_CHECK_EN
  logic dup_error_q;

  // Sticky record of any dropped duplicate read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dup_error_q <= 1'b0;
    end else if (dup_hit) begin
      dup_error_q <= 1'b1;
    end
  end

  assign dup_error = dup_error_q;
`else
  assign dup_error = 1'b0;
`endif

endmodule

// File: tb/tb_returner.sv
// Scoreboard bench for returner. Read beats update a small reorder model;
// whenever the model's head slot fills, the expected (index, data) pair is
// queued. Write beats queue their expected ack if the model says it fits.
// Monitors pop and compare on every output handshake.
module tb_returner;

  localparam int DW   = 16;
  localparam int IW   = 4;
  localparam int NS   = 1 << IW;
  localparam int AD   = 4;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } rd_exp_t;

  logic          clk;
  logic          rst_n;
  logic          returner_valid;
  logic          returner_type;
  logic [DW-1:0] returner_data;
  logic [IW-1:0] returner_index;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [IW-1:0] rd_index;
  logic          wr_ack_valid;
  logic          wr_ack_ready;
  logic [IW-1:0] wr_ack_index;
  logic          wr_overflow;
  logic          dup_error;

  returner #(
    .data_width      (DW),
    .read_entries_log(IW),
    .wr_ack_depth    (AD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .returner_valid(returner_valid),
    .returner_type (returner_type),
    .returner_data (returner_data),
    .returner_index(returner_index),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_index      (rd_index),
    .wr_ack_valid  (wr_ack_valid),
    .wr_ack_ready  (wr_ack_ready),
    .wr_ack_index  (wr_ack_index),
    .wr_overflow   (wr_overflow),
    .dup_error     (dup_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatch = 0;
  int rd_seen    = 0;

  rd_exp_t       rd_exp_q [$];
  logic [IW-1:0] ack_q [$];

  logic          model_full [NS];
  logic [DW-1:0] model_data [NS];
  logic [IW-1:0] model_head;
  logic          exp_dup;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read-side monitor: a handshake seen at the falling edge completes at the next rise.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid && rd_ready) begin
        if (rd_exp_q.size() == 0) begin
          check_val("rd_unexpected", {31'd0, rd_valid}, 32'd0);
        end else begin
          e = rd_exp_q.pop_front();
          check_val("rd_index", {28'd0, rd_index}, {28'd0, e.idx});
          check_val("rd_data", {16'd0, rd_data}, {16'd0, e.data});
          $display("rd  idx=%0d data=0x%04h", rd_index, rd_data);
          rd_seen++;
        end
      end
    end
  end

  // Write-ack monitor.
  initial begin
    logic [IW-1:0] a;
    forever begin
      @(negedge clk);
      if (rst_n && wr_ack_valid && wr_ack_ready) begin
        if (ack_q.size() == 0) begin
          check_val("ack_unexpected", {31'd0, wr_ack_valid}, 32'd0);
        end else begin
          a = ack_q.pop_front();
          check_val("wr_ack_index", {28'd0, wr_ack_index}, {28'd0, a});
          $display("ack idx=%0d", wr_ack_index);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      model_full[i] = 1'b0;
      model_data[i] = '0;
    end
    model_head = '0;
    exp_dup    = 1'b0;
    rd_exp_q.delete();
    ack_q.delete();
  endtask

  task automatic do_reset();
    returner_valid = 1'b0;
    returner_type  = 1'b0;
    returner_data  = '0;
    returner_index = '0;
    rd_ready       = 1'b0;
    wr_ack_ready   = 1'b0;
    rst_n          = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_val("rst_rd_data", {16'd0, rd_data}, 32'd0);
    check_val("rst_rd_index", {28'd0, rd_index}, 32'd0);
    check_val("rst_wr_ack_valid", {31'd0, wr_ack_valid}, 32'd0);
    check_val("rst_wr_ack_index", {28'd0, wr_ack_index}, 32'd0);
    check_val("rst_wr_overflow", {31'd0, wr_overflow}, 32'd0);
    check_val("rst_dup_error", {31'd0, dup_error}, 32'd0);
    rst_n = 1'b1;
  endtask

  // Present one read beat for one edge; returns #1 after the capturing edge.
  task automatic drive_read(input logic [IW-1:0] idx, input logic [DW-1:0] data);
    rd_exp_t e;
    returner_valid = 1'b1;
    returner_type  = 1'b0;
    returner_index = idx;
    returner_data  = data;
`ifdef RETURNER_DUP_CHECK_EN
    if (model_full[idx]) begin
      exp_dup = 1'b1;
    end else begin
      model_full[idx] = 1'b1;
      model_data[idx] = data;
    end
`else
    model_full[idx] = 1'b1;
    model_data[idx] = data;
`endif
    while (model_full[model_head]) begin
      e.idx  = model_head;
      e.data = model_data[model_head];
      rd_exp_q.push_back(e);
      model_full[model_head] = 1'b0;
      model_head = model_head + 1'b1;
    end
    @(posedge clk);
    #1;
    returner_valid = 1'b0;
  endtask

  // Present one write beat; the ack is expected only if the FIFO can take it.
  task automatic drive_write(input logic [IW-1:0] idx);
    returner_valid = 1'b1;
    returner_type  = 1'b1;
    returner_index = idx;
    returner_data  = '0;
    if (ack_q.size() < AD || (wr_ack_ready && ack_q.size() > 0)) begin
      ack_q.push_back(idx);
    end
    @(posedge clk);
    #1;
    returner_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while ((rd_exp_q.size() != 0 || ack_q.size() != 0) && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check_val("drain_rd", rd_exp_q.size(), 32'd0);
    check_val("drain_ack", ack_q.size(), 32'd0);
  endtask

  initial begin
    int seen_before;
    rst_n = 1'b0;

    // Minimum read latency.
    do_reset();
    rd_ready = 1'b1;
    drive_read(4'd0, 16'h1234);
    check_val("lat_edge_n", {31'd0, rd_valid}, 32'd0);
    @(posedge clk); #1;
    check_val("lat_rd_valid", {31'd0, rd_valid}, 32'd1);
    check_val("lat_rd_data", {16'd0, rd_data}, 32'h1234);
    check_val("lat_rd_index", {28'd0, rd_index}, 32'd0);
    wait_drain();

    // Out-of-order arrival, in-order back-to-back delivery.
    do_reset();
    rd_ready = 1'b1;
    drive_read(4'd2, 16'hC002);
    drive_read(4'd1, 16'hC001);
    drive_read(4'd0, 16'hC000);
    check_val("b2b_pre", {31'd0, rd_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_val("b2b_valid", {31'd0, rd_valid}, 32'd1);
      check_val("b2b_index", {28'd0, rd_index}, k);
    end
    @(posedge clk); #1;
    check_val("b2b_post", {31'd0, rd_valid}, 32'd0);
    wait_drain();

    // Backpressure: output held stable, consumed exactly once.
    do_reset();
    drive_read(4'd0, 16'h5A5A);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check_val("hold_valid", {31'd0, rd_valid}, 32'd1);
      check_val("hold_data", {16'd0, rd_data}, 32'h5A5A);
      @(posedge clk); #1;
    end
    rd_ready = 1'b1;
    @(posedge clk); #1;
    check_val("hold_released", {31'd0, rd_valid}, 32'd0);
    drive_read(4'd1, 16'h7777);
    wait_drain();

    // Reset discards buffered reads: stale slot 1 must never appear.
    do_reset();
    drive_read(4'd1, 16'hDEAD);
    do_reset();
    rd_ready = 1'b1;
    drive_read(4'd0, 16'h0F0F);
    wait_drain();
    repeat (4) @(posedge clk);
    #1;

    // Streaming with head wrap.
    do_reset();
    rd_ready = 1'b1;
    seen_before = rd_seen;
    for (int i = 0; i < 20; i++) begin
      drive_read(IW'(i % NS), DW'($urandom));
    end
    drive_read(4'd4, 16'h4444);
    wait_drain();
    check_val("stream_count", rd_seen - seen_before, 32'd21);

    // Ack FIFO: full with a simultaneous pop still accepts.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive_write(IW'(i));
    end
    wr_ack_ready = 1'b1;
    drive_write(4'd5);
    check_val("fullpop_overflow", {31'd0, wr_overflow}, 32'd0);
    wait_drain();
    check_val("fullpop_empty", {31'd0, wr_ack_valid}, 32'd0);

    // Ack FIFO overflow: 7..10 held, 11 dropped.
    wr_ack_ready = 1'b0;
    for (int i = 7; i <= 11; i++) begin
      drive_write(IW'(i));
      if (i == 10) check_val("ovf_before", {31'd0, wr_overflow}, 32'd0);
    end
    check_val("ovf_flag", {31'd0, wr_overflow}, 32'd1);
    check_val("ovf_ack_valid", {31'd0, wr_ack_valid}, 32'd1);
    check_val("ovf_ack_head", {28'd0, wr_ack_index}, 32'd7);
    wr_ack_ready = 1'b1;
    wait_drain();
    check_val("ovf_sticky", {31'd0, wr_overflow}, 32'd1);

    // Duplicate read to an unread slot.
    do_reset();
    rd_ready = 1'b1;
    drive_read(4'd3, 16'hAAAA);
    drive_read(4'd3, 16'hBBBB);
    check_val("dup_error", {31'd0, dup_error}, {31'd0, exp_dup});
    drive_read(4'd0, 16'h0000);
    drive_read(4'd1, 16'h1111);
    drive_read(4'd2, 16'h2222);
    wait_drain();
    check_val("dup_sticky", {31'd0, dup_error}, {31'd0, exp_dup});

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
